// File: rtl/noc_pkg.sv
// Types and defaults shared by the mesh router switch controllers and output port schedulers.
package noc_pkg;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_CREDITS = 4;

    typedef enum logic {SCHED_IDLE, SCHED_LOCKED} sched_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: the first set request at or after ptr, wrapping modulo N_REQ.
module rr_priority_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx
);

    logic        found;
    logic [31:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = (32'(ptr) + i) % N_REQ;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = PTR_W'(pos);
            end
        end
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Per-output-port scheduler: round-robin arbitration, wormhole lock from head to tail,
// and flit transfers gated by a downstream credit counter.
module output_port_scheduler
    import noc_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned CREDITS = DEF_CREDITS,
    localparam int unsigned CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] tail_i,
    input  logic             credit_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             grant_v_o,
    output logic [N_REQ-1:0] pop_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] credit_cnt_o,
    output logic             err_o
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    sched_state_t     state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] credit_cnt;
    logic             err;

    logic [N_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] winner_next;
    logic             has_credit;

    rr_priority_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req(req_i),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );

    always_comb begin
        grant_o    = '0;
        has_credit = (credit_cnt != '0);
        winner     = (state == SCHED_LOCKED) ? owner : pick_idx;
        // Held in reset so that no flit can complete in a reset cycle.
        if (!rst) begin
            if (state == SCHED_LOCKED) begin
                grant_o[owner] = 1'b1;
            end else if (has_credit) begin
                grant_o = pick_gnt;
            end
        end
        grant_v_o   = (|(grant_o & req_i)) && has_credit;
        pop_o       = grant_o & {N_REQ{grant_v_o}};
        winner_next = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCHED_IDLE;
            ptr        <= '0;
            owner      <= '0;
            credit_cnt <= CNT_W'(CREDITS);
            err        <= 1'b0;
        end else begin
            // The pointer moves only when a packet completes.
            if (grant_v_o) begin
                if (tail_i[winner]) begin
                    state <= SCHED_IDLE;
                    ptr   <= winner_next;
                end else begin
                    state <= SCHED_LOCKED;
                    owner <= winner;
                end
            end
            if (grant_v_o && !credit_i) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (!grant_v_o && credit_i) begin
                if (credit_cnt == CNT_W'(CREDITS)) begin
                    err <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + 1'b1;
                end
            end
        end
    end

    assign locked_o     = (state == SCHED_LOCKED);
    assign credit_cnt_o = credit_cnt;
    assign err_o        = err;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler (N_REQ=4, CREDITS=4).
module tb_output_port_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] tail;
    logic       credit_in;
    logic [3:0] grant;
    logic       grant_v;
    logic [3:0] pop;
    logic       locked;
    logic [2:0] credit_cnt;
    logic       err;

    int checks   = 0;
    int failures = 0;

    output_port_scheduler #(
        .N_REQ(4),
        .CREDITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req),
        .tail_i(tail),
        .credit_i(credit_in),
        .grant_o(grant),
        .grant_v_o(grant_v),
        .pop_o(pop),
        .locked_o(locked),
        .credit_cnt_o(credit_cnt),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a falling edge with rst released.
    task automatic do_reset();
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; tail = 4'b0000; credit_in = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            failures++; $display("FAIL reset_grant: got %b expected 0000", grant);
        end
        checks++;
        if (grant_v !== 1'b0 || pop !== 4'b0000 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: got gv=%b pop=%b locked=%b expected 0 0000 0",
                     grant_v, pop, locked);
        end
        checks++;
        if (credit_cnt !== 3'd4 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt: got cnt=%0d err=%b expected 4 0", credit_cnt, err);
        end
        do_reset();
    endtask

    // ptr=0, inputs 1 and 3 send single-flit packets; credit_i keeps the count full.
    task automatic test_round_robin();
        logic [3:0] exp_g [3];
        exp_g = '{4'b0010, 4'b1000, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            req = 4'b1010; tail = 4'b1010; credit_in = 1'b1;
            #1;
            checks++;
            if (grant !== exp_g[i] || grant_v !== 1'b1 || pop !== exp_g[i]) begin
                failures++;
                $display("FAIL rr_grant c%0d: got g=%b gv=%b pop=%b expected g=%b gv=1",
                         i, grant, grant_v, pop, exp_g[i]);
            end
            checks++;
            if (locked !== 1'b0 || credit_cnt !== 3'd4) begin
                failures++;
                $display("FAIL rr_lock c%0d: got locked=%b cnt=%0d expected 0 4",
                         i, locked, credit_cnt);
            end
            @(negedge clk);
        end
    endtask

    // Continues from ptr=2: input 2 sends a 3-flit packet while input 0 waits.
    task automatic test_wormhole();
        logic [3:0] exp_tail [4];
        logic [3:0] exp_g    [4];
        logic       exp_lock [4];
        exp_tail = '{4'b0000, 4'b0000, 4'b0100, 4'b0001};
        exp_g    = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
        exp_lock = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            req = 4'b0101; tail = exp_tail[i]; credit_in = 1'b1;
            #1;
            checks++;
            if (grant !== exp_g[i] || grant_v !== 1'b1 || locked !== exp_lock[i]) begin
                failures++;
                $display("FAIL worm c%0d: got g=%b gv=%b locked=%b expected g=%b gv=1 locked=%b",
                         i, grant, grant_v, locked, exp_g[i], exp_lock[i]);
            end
            @(negedge clk);
        end
    endtask

    // Input 1 streams a long packet with no returning credits, then one credit pulse.
    task automatic test_credit_stall();
        logic [2:0] exp_cnt [8];
        logic       exp_gv  [8];
        exp_cnt = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
        exp_gv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = 4'b0010; tail = 4'b0000; credit_in = (i == 5);
            #1;
            checks++;
            if (grant !== 4'b0010 || grant_v !== exp_gv[i] || credit_cnt !== exp_cnt[i]) begin
                failures++;
                $display("FAIL stall c%0d: got g=%b gv=%b cnt=%0d expected g=0010 gv=%b cnt=%0d",
                         i, grant, grant_v, credit_cnt, exp_gv[i], exp_cnt[i]);
            end
            checks++;
            if (pop !== (exp_gv[i] ? 4'b0010 : 4'b0000)) begin
                failures++; $display("FAIL stall_pop c%0d: got %b", i, pop);
            end
            @(negedge clk);
        end
    endtask

    // Idle with no credits grants nobody; the pointer has advanced past input 0.
    task automatic test_idle_no_credit();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001; tail = 4'b0001; credit_in = 1'b0;
            @(negedge clk);
        end
        req = 4'b0011; tail = 4'b0011; credit_in = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_v !== 1'b0 || credit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL idle_nocredit: got g=%b gv=%b cnt=%0d expected 0000 0 0",
                     grant, grant_v, credit_cnt);
        end
        @(negedge clk);
        credit_in = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0010 || grant_v !== 1'b1) begin
            failures++;
            $display("FAIL idle_ptr: got g=%b gv=%b expected 0010 1", grant, grant_v);
        end
        @(negedge clk);
    endtask

    task automatic test_credit_edges();
        logic [3:0] in_req [8];
        logic       in_cr  [8];
        logic [2:0] exp_cnt [8];
        logic       exp_err [8];
        in_req  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        in_cr   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_cnt = '{3'd4, 3'd3, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = in_req[i]; tail = 4'b0001; credit_in = in_cr[i];
            #1;
            checks++;
            if (credit_cnt !== exp_cnt[i] || err !== exp_err[i]) begin
                failures++;
                $display("FAIL credit c%0d: got cnt=%0d err=%b expected cnt=%0d err=%b",
                         i, credit_cnt, err, exp_cnt[i], exp_err[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req = 4'b1000; tail = 4'b0000; credit_in = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (locked !== 1'b1 || grant !== 4'b1000 || credit_cnt !== 3'd3) begin
            failures++;
            $display("FAIL midpkt_pre: got locked=%b g=%b cnt=%0d expected 1 1000 3",
                     locked, grant, credit_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || locked !== 1'b0 || grant_v !== 1'b0 || credit_cnt !== 3'd4) begin
            failures++;
            $display("FAIL midpkt_rst: got g=%b locked=%b gv=%b cnt=%0d expected 0000 0 0 4",
                     grant, locked, grant_v, credit_cnt);
        end
        @(negedge clk);
        rst = 1'b0; req = 4'b1001; tail = 4'b1001;
        #1;
        checks++;
        if (grant !== 4'b0001 || grant_v !== 1'b1) begin
            failures++;
            $display("FAIL midpkt_after: got g=%b gv=%b expected 0001 1", grant, grant_v);
        end
        @(negedge clk);
    endtask

    // Owner 0 drops its request mid-packet; input 1 must wait for owner 0's tail.
    task automatic test_bubble();
        logic [3:0] in_req  [5];
        logic [3:0] in_tail [5];
        logic [3:0] exp_g   [5];
        logic       exp_gv  [5];
        in_req  = '{4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
        in_tail = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        exp_g   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        exp_gv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = in_req[i]; tail = in_tail[i]; credit_in = 1'b0;
            #1;
            checks++;
            if (grant !== exp_g[i] || grant_v !== exp_gv[i]) begin
                failures++;
                $display("FAIL bubble c%0d: got g=%b gv=%b expected g=%b gv=%b",
                         i, grant, grant_v, exp_g[i], exp_gv[i]);
            end
            checks++;
            if (pop !== (exp_gv[i] ? exp_g[i] : 4'b0000)) begin
                failures++; $display("FAIL bubble_pop c%0d: got %b", i, pop);
            end
            @(negedge clk);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL bubble_end: got locked=%b expected 0", locked);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_stall();
        test_idle_no_credit();
        test_credit_edges();
        test_reset_mid_packet();
        test_bubble();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
